pc_ctrl: RTL
============

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- XLEN, 32, PC and branch-target width.
- RESET_PC, 32'h00003000, PC value loaded on reset.
- PC_STEP, 4, linear increment per advancing cycle.
- BR_DEPTH, 2, cycles from branch request to PC redirect; range 0..7, where 0 means the redirect applies on the next edge.
- EXC_W, 8, exception code width.
- STALL_CODE, 8'h01, exception code that means stall, not fault.
- MISALIGN_CODE, 8'h80, halt code for a misaligned branch target.
- CNT_W, 64, cycle counter width.

REQ-002 SHALL have ports, one per line: name direction width meaning:
- clk input 1 clock.
- rst input 1 reset, synchronous, active-high.
- stall_i input 1 hold PC this cycle.
- br_en_i input 1 branch request valid.
- br_target_i input XLEN branch target.
- exc_i input EXC_W exception code from writeback; 0 means none.
- pc_o output XLEN current fetch PC.
- br_taken_o output 1 the PC of the previous edge was a redirect.
- halted_o output 1 a fault has been latched.
- done_o output 1 simulation or core may terminate.
- halt_code_o output EXC_W latched fault code.
- cycle_cnt_o output CNT_W cycle counter.

Function
REQ-003 SHALL implement state machine RUN -> HALT -> DONE; DONE is absorbing and only rst leaves it.
REQ-004 SHALL delay each (br_en_i, br_target_i) pair through a BR_DEPTH-stage shift line; the line shifts every cycle, including stall cycles.
REQ-005 SHALL, in RUN, when a valid delayed request emerges with target[1:0]==0: load pc_o with the target and set br_taken_o=1 on the same edge.
REQ-006 SHALL, in RUN, with no emerging request and stall_i=0: load pc_o with pc_o+PC_STEP modulo 2^XLEN and set br_taken_o=0.
REQ-007 SHALL, in RUN, with no emerging request and stall_i=1: hold pc_o and set br_taken_o=0.
REQ-008 SHALL give an emerging branch priority over stall_i.
REQ-009 SHALL, in RUN, when exc_i!=0 and exc_i!=STALL_CODE: go to HALT, latch exc_i into halt_code_o, hold pc_o, and ignore any emerging branch on that edge.
REQ-010 SHALL treat exc_i==STALL_CODE as equivalent to stall_i=1.
REQ-011 SHALL, in RUN, for an emerging branch with target[1:0]!=0 and no fault on exc_i: go to HALT with halt_code_o=MISALIGN_CODE and pc_o held.
REQ-012 SHALL give a fault on exc_i priority over a misaligned branch when both occur on the same edge.
REQ-013 SHALL, on entering HALT, clear every stage of the branch delay line.
REQ-014 SHALL keep halted_o=1 in HALT and DONE.
REQ-015 SHALL move HALT -> DONE unconditionally after exactly one cycle; done_o=1 only in DONE.
REQ-016 SHALL, in HALT and DONE: freeze pc_o, keep br_taken_o=0, freeze halt_code_o, and ignore br_en_i, stall_i and exc_i.
REQ-017 SHALL increment cycle_cnt_o on every non-reset edge in all states, wrapping modulo 2^CNT_W.
REQ-018 SHALL, with BR_DEPTH=0, apply a request present at an edge on that same edge.

Reset
REQ-019 SHALL, on rst=1 at an edge, set: pc_o=RESET_PC, br_taken_o=0, halted_o=0, done_o=0, halt_code_o=0, cycle_cnt_o=1, state=RUN, all delay stages invalid.
REQ-020 SHALL let rst override every other input, including mid-HALT, mid-DONE, and while branches are in flight; in-flight branches are discarded.

Verification
REQ-021 Reset then 3 idle cycles -> pc_o: 0x3000, 0x3004, 0x3008, 0x300C; cycle_cnt_o: 1, 2, 3, 4.
REQ-022 BR_DEPTH=2; br_en_i=1, target 0x3100 at edge N -> pc_o=0x3100 and br_taken_o=1 after edge N+2; pc_o=0x3104 and br_taken_o=0 after N+3.
REQ-023 stall_i=1 held across the edge where the REQ-022 branch emerges -> redirect still occurs; stall_i=1 with no branch -> pc_o unchanged for each stalled cycle.
REQ-024 exc_i=8'h04 on the edge where a branch emerges -> pc_o held, halted_o=1, halt_code_o=8'h04; done_o=1 one cycle later; a later br_en_i has no effect.
REQ-025 Branch target 0x3102 -> halt_code_o=8'h80 and pc_o unchanged; exc_i=STALL_CODE -> no halt, PC holds.
REQ-026 rst asserted in DONE with a branch queued just before the halt -> all REQ-019 values, and no redirect occurs afterwards.

Source files
------------

// File: rtl/pc_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_ctrl_if
//
// Purpose:
//    Groups the fetch-control signals of pc_ctrl into one bundle so the
//    controller and whatever drives it share a single port.
//
// Signals (named from the controller's point of view):
//    stall_i      hold the PC this cycle
//    br_en_i      branch request valid
//    br_target_i  branch target address
//    exc_i        exception code from writeback, 0 means none
//    pc_o         current fetch PC
//    br_taken_o   the PC loaded on the previous edge was a redirect
//    halted_o     a fault has been latched
//    done_o       the core may terminate
//    halt_code_o  latched fault code
//    cycle_cnt_o  free-running cycle counter
//
// Modports:
//    master  the requester side, which drives the *_i signals
//    slave   the controller side, which drives the *_o signals
// ---------------------------------------------------------------------------
interface pc_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int EXC_W = 8,
   parameter int CNT_W = 64
);

   logic             stall_i;
   logic             br_en_i;
   logic [XLEN-1:0]  br_target_i;
   logic [EXC_W-1:0] exc_i;

   logic [XLEN-1:0]  pc_o;
   logic             br_taken_o;
   logic             halted_o;
   logic             done_o;
   logic [EXC_W-1:0] halt_code_o;
   logic [CNT_W-1:0] cycle_cnt_o;

   modport master (
      output stall_i,
      output br_en_i,
      output br_target_i,
      output exc_i,
      input  pc_o,
      input  br_taken_o,
      input  halted_o,
      input  done_o,
      input  halt_code_o,
      input  cycle_cnt_o
   );

   modport slave (
      input  stall_i,
      input  br_en_i,
      input  br_target_i,
      input  exc_i,
      output pc_o,
      output br_taken_o,
      output halted_o,
      output done_o,
      output halt_code_o,
      output cycle_cnt_o
   );

endinterface

// File: rtl/pc_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ctrl
//
// Purpose:
//    Program-counter controller for a simple fetch stage. The PC advances
//    linearly, holds on stall, and is redirected by branch requests that
//    arrive BR_DEPTH cycles before they take effect (modelling the pipeline
//    distance between branch resolution and fetch). A non-stall exception
//    code or a misaligned branch target halts the controller. It then
//    reports done one cycle later and stays there until reset.
//
// Ports:
//    clk   clock
//    rst   synchronous, active-high reset
//    bus   pc_ctrl_if.slave carrying the stall, branch and exception inputs
//          and the pc, br_taken, halted, done, halt_code and cycle_cnt
//          outputs
//
// Parameters:
//    XLEN           PC and branch-target width
//    RESET_PC       PC loaded on reset
//    PC_STEP        linear increment per advancing cycle
//    BR_DEPTH       branch request to redirect distance in cycles (0..7);
//                   0 applies a request on the edge where it is presented
//    EXC_W          exception code width
//    STALL_CODE     exception code that means "stall", not a fault
//    MISALIGN_CODE  halt code recorded for a misaligned branch target
//    CNT_W          cycle counter width
// ---------------------------------------------------------------------------
module pc_ctrl #(
   parameter int               XLEN          = 32,
   parameter logic [XLEN-1:0]  RESET_PC      = 32'h00003000,
   parameter int               PC_STEP       = 4,
   parameter int               BR_DEPTH      = 2,
   parameter int               EXC_W         = 8,
   parameter logic [EXC_W-1:0] STALL_CODE    = 8'h01,
   parameter logic [EXC_W-1:0] MISALIGN_CODE = 8'h80,
   parameter int               CNT_W         = 64
) (
   input  logic     clk,
   input  logic     rst,
   pc_ctrl_if.slave bus
);

   // Controller states. RUN fetches normally; HALT lasts exactly one cycle
   // after a fault; DONE is absorbing until reset.
   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_HALT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [XLEN-1:0]  r_pc;
   logic             r_brTaken;
   logic [EXC_W-1:0] r_haltCode;
   logic [CNT_W-1:0] r_cycleCnt;

   logic             w_emergeValid;
   logic [XLEN-1:0]  w_emergeTarget;
   logic             w_isFault;
   logic             w_isStall;
   logic             w_misaligned;
   logic             w_enterHalt;
   logic             w_clearLine;

   // Classify the inputs once. A stall-code exception behaves like
   // stall_i. Any other non-zero code is a fault, and a fault outranks
   // everything else on the same edge.
   assign w_isFault    = (bus.exc_i != '0) && (bus.exc_i != STALL_CODE);
   assign w_isStall    = bus.stall_i || (bus.exc_i == STALL_CODE);
   assign w_misaligned = w_emergeValid && (w_emergeTarget[1:0] != 2'b00);

   // The delay line is flushed on the edge that enters HALT and then kept
   // empty for as long as the controller is not running, so no stale
   // request can surface after a halt.
   assign w_enterHalt  = (r_state == ST_RUN) && (w_isFault || w_misaligned);
   assign w_clearLine  = w_enterHalt || (r_state != ST_RUN);

   // Branch delay line. With BR_DEPTH of zero the request is used on the
   // edge where it is presented, so no storage exists at all. Otherwise
   // stage 0 captures the live request and the last stage is the one that
   // emerges. The line shifts on every running cycle, stalled or not.
   generate
      if (BR_DEPTH == 0) begin : gNoDelay
         assign w_emergeValid  = bus.br_en_i;
         assign w_emergeTarget = bus.br_target_i;
      end else begin : gDelay
         logic [BR_DEPTH-1:0] r_lineValid;
         logic [XLEN-1:0]     r_lineTarget [BR_DEPTH];

         always_ff @(posedge clk) begin
            if (rst || w_clearLine) begin
               r_lineValid <= '0;
               for (int i = 0; i < BR_DEPTH; i++) begin
                  r_lineTarget[i] <= '0;
               end
            end else begin
               r_lineValid[0]  <= bus.br_en_i;
               r_lineTarget[0] <= bus.br_target_i;
               for (int i = 1; i < BR_DEPTH; i++) begin
                  r_lineValid[i]  <= r_lineValid[i-1];
                  r_lineTarget[i] <= r_lineTarget[i-1];
               end
            end
         end

         assign w_emergeValid  = r_lineValid[BR_DEPTH-1];
         assign w_emergeTarget = r_lineTarget[BR_DEPTH-1];
      end
   endgenerate

   // Free-running cycle counter. Reset loads 1 so that the first cycle
   // after reset reads as cycle 1; it keeps counting through HALT and DONE
   // and wraps naturally at its width.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycleCnt <= CNT_W'(1);
      end else begin
         r_cycleCnt <= r_cycleCnt + CNT_W'(1);
      end
   end

   // Main control FSM and PC register. In RUN the priority is:
   // fault on exc_i, then an emerging branch (misaligned ones halt),
   // then stall, then a linear step. HALT and DONE ignore all inputs and
   // freeze the PC and halt code.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_brTaken  <= 1'b0;
         r_haltCode <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_isFault) begin
                  r_state    <= ST_HALT;
                  r_haltCode <= bus.exc_i;
                  r_brTaken  <= 1'b0;
               end else if (w_emergeValid) begin
                  if (w_misaligned) begin
                     r_state    <= ST_HALT;
                     r_haltCode <= MISALIGN_CODE;
                     r_brTaken  <= 1'b0;
                  end else begin
                     r_pc      <= w_emergeTarget;
                     r_brTaken <= 1'b1;
                  end
               end else if (w_isStall) begin
                  r_brTaken <= 1'b0;
               end else begin
                  r_pc      <= r_pc + XLEN'(PC_STEP);
                  r_brTaken <= 1'b0;
               end
            end
            ST_HALT: begin
               r_state   <= ST_DONE;
               r_brTaken <= 1'b0;
            end
            ST_DONE: begin
               r_brTaken <= 1'b0;
            end
            default: begin
               r_state   <= ST_DONE;
               r_brTaken <= 1'b0;
            end
         endcase
      end
   end

   // Status outputs decode straight from the state register.
   assign bus.pc_o        = r_pc;
   assign bus.br_taken_o  = r_brTaken;
   assign bus.halted_o    = (r_state != ST_RUN);
   assign bus.done_o      = (r_state == ST_DONE);
   assign bus.halt_code_o = r_haltCode;
   assign bus.cycle_cnt_o = r_cycleCnt;

endmodule
